// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port
// between NUM_REQ bursting producers. A grant is locked for one burst
// (ended by req_last or by MAX_BURST beats), and FIFO-full backpressure
// is applied only to the current owner.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wren,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [31:0]                   beat_cnt
);

  localparam int GW = $clog2(NUM_REQ);
  // Wide enough to hold MAX_BURST itself, and at least one bit when MAX_BURST=1.
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   last_owner_q, last_owner_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [31:0]     beat_cnt_q, beat_cnt_d;
  logic            accept;
  logic            release_now;

  // First valid requester searching upward from last+1 with wrap-around.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic [GW-1:0] idx_w;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = GW'(idx);
      if (!found && v[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign busy      = (state_q == GRANT);
  assign accept    = busy & req_valid[grant_id_q] & ~fifo_full;
  assign fifo_wren = accept;
  assign fifo_data = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id  = grant_id_q;
  assign beat_cnt  = beat_cnt_q;

  // The burst ends on the owner's last beat or on the beat that fills the cap.
  assign release_now = req_last[grant_id_q] | (burst_q == BW'(MAX_BURST - 1));

  // Only the current owner ever sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready             = '0;
    req_ready[grant_id_q] = busy & ~fifo_full;
  end

  // Next-state: arbitrate in IDLE, count beats and detect release in GRANT.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_id_d = rr_pick(req_valid, last_owner_q);
          burst_d    = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
          burst_d    = burst_q + BW'(1);
          if (release_now) begin
            last_owner_d = grant_id_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves producer 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_owner_q <= GW'(NUM_REQ - 1);
      burst_q      <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule
